// File: rtl/assert_event_monitor_pkg.sv
// Shared types and helpers for the multi-channel assertion/event monitor.
// Holds the per-channel check mode and a width helper that tolerates 1-entry ranges.
package assert_mon_pkg;

   typedef enum logic {
      MODE_SAFETY   = 1'b0,
      MODE_LIVENESS = 1'b1
   } mode_e;

   // $clog2 returns 0 for 1; every index/counter here needs at least one bit
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/assert_event_monitor_if.sv
// Channel inputs, status outputs and report handshake of the event monitor.
// slave = monitor side, master = stimulus/consumer side.
interface assert_mon_if #(
   parameter int NCH  = 4,
   parameter int CW   = 32,
   parameter int CNTW = 16
);
   localparam int CHW = assert_mon_pkg::clog2_min1(NCH);

   logic [NCH-1:0]  io_en;
   logic [NCH-1:0]  io_ok;
   logic [NCH-1:0]  io_pend;
   logic            io_clear;
   logic [NCH-1:0]  io_sticky;
   logic            io_any_err;
   logic [CHW-1:0]  io_first_ch;
   logic [CW-1:0]   io_first_cyc;
   logic [CNTW-1:0] io_err_count;
   logic            io_rpt_valid;
   logic            io_rpt_ready;
   logic [CHW-1:0]  io_rpt_ch;
   logic [CW-1:0]   io_rpt_cyc;
   logic            io_rpt_ovf;

   modport slave (
      input  io_en, io_ok, io_pend, io_clear, io_rpt_ready,
      output io_sticky, io_any_err, io_first_ch, io_first_cyc, io_err_count,
             io_rpt_valid, io_rpt_ch, io_rpt_cyc, io_rpt_ovf
   );

   modport master (
      output io_en, io_ok, io_pend, io_clear, io_rpt_ready,
      input  io_sticky, io_any_err, io_first_ch, io_first_cyc, io_err_count,
             io_rpt_valid, io_rpt_ch, io_rpt_cyc, io_rpt_ovf
   );
endinterface

// File: rtl/assert_event_monitor_fifo.sv
// Generic FIFO: push visible at head next cycle (no bypass); push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise the caller sees o_full.
module assert_report_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  T     i_dat,
   input  logic i_pop,
   output T     o_dat,
   output logic o_full,
   output logic o_empty
);
   localparam int AW = $clog2(DEPTH);

   T           r_mem [DEPTH];
   logic [AW:0] r_wr;
   logic [AW:0] r_rd;
   logic        w_do_push;
   logic        w_do_pop;

   assign o_empty   = (r_wr == r_rd);
   assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_dat     = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_dat;
   end
endmodule

// File: rtl/assert_event_monitor.sv
// Multi-channel safety/liveness monitor: 0-cycle detection, status 1 cycle later.
// Reports queue in a FIFO drained by valid/ready; reports arriving while full are dropped.
module assert_event_monitor
   import assert_mon_pkg::*;
#(
   parameter int             NCH          = 4,
   parameter logic [NCH-1:0] MODE         = '0,
   parameter int             TIMEOUT      = 64,
   parameter int             HOLDOFF      = 8,
   parameter int             CW           = 32,
   parameter int             CNTW         = 16,
   parameter int             REPORT_DEPTH = 4,
   parameter bit             FATAL_EN     = 1'b1
) (
   input logic         clock,
   input logic         reset,
   assert_mon_if.slave mon
);
   localparam int CHW = clog2_min1(NCH);
   localparam int TW  = clog2_min1(TIMEOUT + 1);
   localparam int HW  = clog2_min1(HOLDOFF + 1);

   typedef struct packed {
      logic [CHW-1:0] ch;
      logic [CW-1:0]  cyc;
   } rpt_entry_t;

   logic [CW-1:0]   r_cyc;
   logic [HW-1:0]   r_holdoff;
   logic [NCH-1:0]  r_sticky;
   logic            r_captured;
   logic [CHW-1:0]  r_first_ch;
   logic [CW-1:0]   r_first_cyc;
   logic [CNTW-1:0] r_count;
   logic            r_ovf;

   logic            w_armed;
   logic [NCH-1:0]  w_viol;
   logic            w_any;
   logic [CHW-1:0]  w_low_ch;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   rpt_entry_t      w_push_ent;
   rpt_entry_t      w_head;

   assign w_armed = (r_holdoff == '0);
   assign w_any   = |w_viol;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      if (mode_e'(MODE[i]) == MODE_LIVENESS) begin : g_live
         logic [TW-1:0] r_timer;
         logic          w_expire;
         // Timer restarts on expiry even in holdoff, so a stuck request re-fires each TIMEOUT
         assign w_expire  = mon.io_pend[i] & ~mon.io_ok[i] & (r_timer == TW'(TIMEOUT - 1));
         assign w_viol[i] = w_expire & w_armed;
         always_ff @(posedge clock or posedge reset) begin
            if (reset)                                             r_timer <= '0;
            else if (mon.io_ok[i] | ~mon.io_pend[i] | w_expire)    r_timer <= '0;
            else                                                   r_timer <= r_timer + 1'b1;
         end
      end else begin : g_safe
         assign w_viol[i] = w_armed & mon.io_en[i] & ~mon.io_ok[i];
      end
   end

   always_comb begin
      w_low_ch = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (w_viol[i]) w_low_ch = CHW'(i);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cyc       <= '0;
         r_holdoff   <= HW'(HOLDOFF);
         r_sticky    <= '0;
         r_captured  <= 1'b0;
         r_first_ch  <= '0;
         r_first_cyc <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_cyc    <= r_cyc + 1'b1;
         if (!w_armed) r_holdoff <= r_holdoff - 1'b1;
         r_sticky <= (r_sticky & ~{NCH{mon.io_clear}}) | w_viol;
         // A clear coinciding with a violation re-arms capture and takes this violation
         if (w_any && (!r_captured || mon.io_clear)) begin
            r_captured  <= 1'b1;
            r_first_ch  <= w_low_ch;
            r_first_cyc <= r_cyc;
         end else if (mon.io_clear) begin
            r_captured  <= 1'b0;
            r_first_ch  <= '0;
            r_first_cyc <= '0;
         end
         if (mon.io_clear)                r_count <= w_any ? CNTW'(1) : '0;
         else if (w_any && r_count != '1) r_count <= r_count + 1'b1;
         r_ovf <= (r_ovf & ~mon.io_clear) | (w_any & w_full & ~w_pop);
      end
   end

   assign w_push_ent.ch  = w_low_ch;
   assign w_push_ent.cyc = r_cyc;
   assign w_pop          = mon.io_rpt_ready & ~w_empty;

   assert_report_fifo #(.DEPTH(REPORT_DEPTH), .T(rpt_entry_t)) u_rpt_fifo (
      .clk     (clock),
      .rst     (reset),
      .i_push  (w_any),
      .i_dat   (w_push_ent),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign mon.io_sticky    = r_sticky;
   assign mon.io_any_err   = |r_sticky;
   assign mon.io_first_ch  = r_first_ch;
   assign mon.io_first_cyc = r_first_cyc;
   assign mon.io_err_count = r_count;
   assign mon.io_rpt_valid = ~w_empty;
   assign mon.io_rpt_ch    = w_empty ? '0 : w_head.ch;
   assign mon.io_rpt_cyc   = w_empty ? '0 : w_head.cyc;
   assign mon.io_rpt_ovf   = r_ovf;

`ifndef SYNTHESIS
   logic w_printf_en;
   logic w_stop_en;
   assign w_printf_en = 1'b1;
   assign w_stop_en   = 1'b1;
   always @(posedge clock) begin
      if (!reset && w_any) begin
         if (w_printf_en)
            $display("assert_event_monitor: channel %0d tripped at cycle %0d",
                     w_low_ch, r_cyc);
         if (FATAL_EN && w_stop_en)
            $fatal(1, "assert_event_monitor: channel %0d tripped at cycle %0d", w_low_ch, r_cyc);
      end
   end
`endif
endmodule

// File: tb/tb_assert_event_monitor.sv
// Directed bench for assert_event_monitor: ch1 liveness (TIMEOUT=4), others safety,
// HOLDOFF=8, 2-bit counter, 4-entry report FIFO.
module tb_assert_event_monitor;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;

   assert_mon_if #(.NCH(4), .CW(32), .CNTW(2)) bus ();

   assert_event_monitor #(
      .NCH(4), .MODE(4'b0010), .TIMEOUT(4), .HOLDOFF(8), .CW(32), .CNTW(2),
      .REPORT_DEPTH(4), .FATAL_EN(1'b0)
   ) dut (
      .clock (clock),
      .reset (reset),
      .mon   (bus.slave)
   );

   always #5 clock = ~clock;

   // advance n clock edges; cyc mirrors the DUT cycle counter
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
         if (!reset) cyc++;
      end
   endtask

   task automatic quiesce();
      bus.io_en = '0; bus.io_ok = '0; bus.io_pend = '0;
      bus.io_clear = 1'b1; bus.io_rpt_ready = 1'b1;
      step(1);
      bus.io_clear = 1'b0;
      step(4);
      bus.io_rpt_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.io_en = 4'b0001; bus.io_ok = '0; bus.io_pend = '0;
      bus.io_clear = 1'b0; bus.io_rpt_ready = 1'b0;
      step(2);
      checks++; if ({bus.io_sticky, bus.io_any_err, bus.io_first_ch, bus.io_first_cyc, bus.io_err_count, bus.io_rpt_valid, bus.io_rpt_ch, bus.io_rpt_cyc, bus.io_rpt_ovf} !== '0) begin failures++; $display("FAIL reset_outputs sticky=%b cnt=%0d valid=%b", bus.io_sticky, bus.io_err_count, bus.io_rpt_valid); end
   endtask

   task automatic test_holdoff();
      reset = 1'b0; cyc = 0;
      step(8);
      checks++; if (bus.io_sticky !== 4'b0000) begin failures++; $display("FAIL holdoff_sticky got=%b want=0000", bus.io_sticky); end
      checks++; if (bus.io_rpt_valid !== 1'b0) begin failures++; $display("FAIL holdoff_valid got=%b want=0", bus.io_rpt_valid); end
      step(1);
      checks++; if (bus.io_sticky !== 4'b0001 || bus.io_any_err !== 1'b1) begin failures++; $display("FAIL armed_sticky got=%b any=%b want=0001/1", bus.io_sticky, bus.io_any_err); end
      checks++; if (bus.io_first_ch !== 2'd0 || bus.io_first_cyc !== 32'd8) begin failures++; $display("FAIL armed_first got=%0d@%0d want=0@8", bus.io_first_ch, bus.io_first_cyc); end
      checks++; if (bus.io_rpt_valid !== 1'b1 || bus.io_rpt_cyc !== 32'd8 || bus.io_err_count !== 2'd1) begin failures++; $display("FAIL armed_report got=v%b cyc%0d cnt%0d want=v1 cyc8 cnt1", bus.io_rpt_valid, bus.io_rpt_cyc, bus.io_err_count); end
      bus.io_en = '0;
   endtask

   task automatic test_liveness();
      int unsigned c0;
      quiesce();
      c0 = cyc;
      bus.io_pend = 4'b0010;
      step(3);
      checks++; if (bus.io_err_count !== 2'd0 || bus.io_sticky !== 4'b0000) begin failures++; $display("FAIL live_early got=cnt%0d st%b want=cnt0 st0000", bus.io_err_count, bus.io_sticky); end
      step(1);
      checks++; if (bus.io_err_count !== 2'd1 || bus.io_sticky !== 4'b0010) begin failures++; $display("FAIL live_first got=cnt%0d st%b want=cnt1 st0010", bus.io_err_count, bus.io_sticky); end
      checks++; if (bus.io_rpt_ch !== 2'd1 || bus.io_rpt_cyc !== c0 + 3 || bus.io_first_cyc !== c0 + 3) begin failures++; $display("FAIL live_stamp got=ch%0d cyc%0d first%0d want=ch1 cyc%0d", bus.io_rpt_ch, bus.io_rpt_cyc, bus.io_first_cyc, c0 + 3); end
      step(4);
      checks++; if (bus.io_err_count !== 2'd2) begin failures++; $display("FAIL live_second got=%0d want=2", bus.io_err_count); end
      step(4);
      checks++; if (bus.io_err_count !== 2'd3) begin failures++; $display("FAIL live_third got=%0d want=3", bus.io_err_count); end
      quiesce();
      bus.io_pend = 4'b0010;
      step(3);
      bus.io_ok = 4'b0010;
      step(1);
      bus.io_ok = '0;
      step(3);
      bus.io_pend = '0;
      step(1);
      checks++; if (bus.io_err_count !== 2'd0 || bus.io_sticky !== 4'b0000 || bus.io_rpt_valid !== 1'b0) begin failures++; $display("FAIL live_ok_wins got=cnt%0d st%b v%b want=0/0000/0", bus.io_err_count, bus.io_sticky, bus.io_rpt_valid); end
   endtask

   task automatic test_simultaneous();
      int unsigned c0;
      quiesce();
      c0 = cyc;
      bus.io_en = 4'b1100;
      step(1);
      bus.io_en = '0;
      checks++; if (bus.io_sticky !== 4'b1100 || bus.io_err_count !== 2'd1) begin failures++; $display("FAIL sim_sticky got=%b cnt%0d want=1100 cnt1", bus.io_sticky, bus.io_err_count); end
      checks++; if (bus.io_first_ch !== 2'd2 || bus.io_first_cyc !== c0) begin failures++; $display("FAIL sim_first got=%0d@%0d want=2@%0d", bus.io_first_ch, bus.io_first_cyc, c0); end
      checks++; if (bus.io_rpt_ch !== 2'd2 || bus.io_rpt_cyc !== c0) begin failures++; $display("FAIL sim_report got=%0d@%0d want=2@%0d", bus.io_rpt_ch, bus.io_rpt_cyc, c0); end
      bus.io_rpt_ready = 1'b1;
      step(1);
      checks++; if (bus.io_rpt_valid !== 1'b0) begin failures++; $display("FAIL sim_single_entry got=%b want=0", bus.io_rpt_valid); end
   endtask

   task automatic test_overflow();
      int unsigned c0;
      quiesce();
      c0 = cyc;
      bus.io_en = 4'b0001;
      step(4);
      checks++; if (bus.io_rpt_ovf !== 1'b0) begin failures++; $display("FAIL ovf_at_full got=%b want=0", bus.io_rpt_ovf); end
      step(2);
      checks++; if (bus.io_rpt_ovf !== 1'b1 || bus.io_err_count !== 2'd3) begin failures++; $display("FAIL ovf_set got=ovf%b cnt%0d want=ovf1 cnt3", bus.io_rpt_ovf, bus.io_err_count); end
      bus.io_en = '0;
      step(1);
      checks++; if (bus.io_rpt_valid !== 1'b1 || bus.io_rpt_cyc !== c0) begin failures++; $display("FAIL ovf_head_stable got=v%b %0d want=v1 %0d", bus.io_rpt_valid, bus.io_rpt_cyc, c0); end
      bus.io_rpt_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (bus.io_rpt_valid !== 1'b1 || bus.io_rpt_cyc !== c0 + k) begin failures++; $display("FAIL ovf_drain%0d got=v%b %0d want=v1 %0d", k, bus.io_rpt_valid, bus.io_rpt_cyc, c0 + k); end
         step(1);
      end
      checks++; if (bus.io_rpt_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b want=0", bus.io_rpt_valid); end
   endtask

   task automatic test_back_to_back();
      int unsigned c0;
      quiesce();
      c0 = cyc;
      bus.io_en = 4'b0001;
      step(4);
      bus.io_rpt_ready = 1'b1;
      step(1);
      bus.io_en = '0;
      checks++; if (bus.io_rpt_ovf !== 1'b0 || bus.io_rpt_cyc !== c0 + 1) begin failures++; $display("FAIL b2b_full_push_pop got=ovf%b %0d want=ovf0 %0d", bus.io_rpt_ovf, bus.io_rpt_cyc, c0 + 1); end
      for (int k = 1; k <= 4; k++) begin
         checks++; if (bus.io_rpt_valid !== 1'b1 || bus.io_rpt_cyc !== c0 + k) begin failures++; $display("FAIL b2b_drain%0d got=v%b %0d want=v1 %0d", k, bus.io_rpt_valid, bus.io_rpt_cyc, c0 + k); end
         step(1);
      end
      checks++; if (bus.io_rpt_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b want=0", bus.io_rpt_valid); end
   endtask

   task automatic test_clear();
      int unsigned c0;
      quiesce();
      c0 = cyc;
      bus.io_en = 4'b0101;
      step(1);
      bus.io_en = 4'b0001;
      step(4);
      checks++; if (bus.io_err_count !== 2'd3 || bus.io_sticky !== 4'b0101 || bus.io_first_cyc !== c0) begin failures++; $display("FAIL clr_saturate got=cnt%0d st%b first%0d want=cnt3 st0101 first%0d", bus.io_err_count, bus.io_sticky, bus.io_first_cyc, c0); end
      bus.io_clear = 1'b1;
      step(1);
      checks++; if (bus.io_sticky !== 4'b0001 || bus.io_err_count !== 2'd1) begin failures++; $display("FAIL clr_with_viol got=st%b cnt%0d want=st0001 cnt1", bus.io_sticky, bus.io_err_count); end
      checks++; if (bus.io_first_ch !== 2'd0 || bus.io_first_cyc !== c0 + 5 || bus.io_rpt_ovf !== 1'b1) begin failures++; $display("FAIL clr_recapture got=%0d@%0d ovf%b want=0@%0d ovf1", bus.io_first_ch, bus.io_first_cyc, bus.io_rpt_ovf, c0 + 5); end
      bus.io_en = '0;
      step(1);
      bus.io_clear = 1'b0;
      checks++; if (bus.io_sticky !== 4'b0000 || bus.io_err_count !== 2'd0 || bus.io_first_cyc !== 32'd0 || bus.io_rpt_ovf !== 1'b0) begin failures++; $display("FAIL clr_plain got=st%b cnt%0d first%0d ovf%b want=all0", bus.io_sticky, bus.io_err_count, bus.io_first_cyc, bus.io_rpt_ovf); end
      checks++; if (bus.io_rpt_valid !== 1'b1) begin failures++; $display("FAIL clr_keeps_fifo got=%b want=1", bus.io_rpt_valid); end
   endtask

   task automatic test_midrun_reset();
      quiesce();
      bus.io_en = 4'b0001;
      step(2);
      checks++; if (bus.io_rpt_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b want=1", bus.io_rpt_valid); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({bus.io_sticky, bus.io_any_err, bus.io_first_ch, bus.io_first_cyc, bus.io_err_count, bus.io_rpt_valid, bus.io_rpt_ch, bus.io_rpt_cyc, bus.io_rpt_ovf} !== '0) begin failures++; $display("FAIL rst_async_outputs sticky=%b cnt=%0d valid=%b", bus.io_sticky, bus.io_err_count, bus.io_rpt_valid); end
      step(2);
      reset = 1'b0; cyc = 0;
      step(8);
      checks++; if (bus.io_sticky !== 4'b0000) begin failures++; $display("FAIL rst_holdoff got=%b want=0000", bus.io_sticky); end
      step(1);
      checks++; if (bus.io_sticky !== 4'b0001 || bus.io_first_cyc !== 32'd8) begin failures++; $display("FAIL rst_rearmed got=st%b first%0d want=0001 first8", bus.io_sticky, bus.io_first_cyc); end
      bus.io_en = '0;
   endtask

   initial begin
      test_reset();
      test_holdoff();
      test_liveness();
      test_simultaneous();
      test_overflow();
      test_back_to_back();
      test_clear();
      test_midrun_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
